// File: rtl/dw_rowbuff_ctrl.sv
// Depthwise 3x3 row-buffer sequencer: loads the buffer length, gates one frame of pixels
// into the buffer, tracks column/row position and flags the pixels that complete a 3x3 window.
module dw_rowbuff_ctrl #(
   parameter int COL_W   = 9,
   parameter int ROW_W   = 9,
   parameter int MIN_DIM = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic [COL_W-1:0] cfg_cols,
   input  logic [ROW_W-1:0] cfg_rows,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             buf_valid_in,
   output logic [COL_W-1:0] buf_len_ctrl,
   output logic             buf_len_rst,
   output logic             win_valid,
   output logic [COL_W-1:0] col_cnt,
   output logic [ROW_W-1:0] row_cnt,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [COL_W-1:0] cols_last;
   logic [ROW_W-1:0] rows_last;
   logic             dims_ok;
   logic             start_ok;
   logic             accept;
   logic             col_end;
   logic             last_pix;

   assign dims_ok  = (cfg_cols >= COL_W'(MIN_DIM)) && (cfg_rows >= ROW_W'(MIN_DIM));
   assign start_ok = (state == IDLE) && cfg_start && dims_ok && !cfg_abort;

   // An accept in the abort cycle still reaches the buffer; only the state is discarded.
   assign s_ready      = (state == RUN);
   assign accept       = s_valid & s_ready;
   assign buf_valid_in = accept;
   assign col_end      = (col_cnt == cols_last);
   assign last_pix     = accept && col_end && (row_cnt == rows_last);
   assign win_valid    = accept && (row_cnt >= ROW_W'(2)) && (col_cnt >= COL_W'(2));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      buf_len_rst = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (state)
         IDLE: if (start_ok) state_nxt = LOAD;
         LOAD: begin
            buf_len_rst = 1'b1;
            busy        = 1'b1;
            state_nxt   = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_pix) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (cfg_abort) state_nxt = IDLE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cols_last    <= '0;
         rows_last    <= '0;
         buf_len_ctrl <= '0;
         col_cnt      <= '0;
         row_cnt      <= '0;
         cfg_err      <= 1'b0;
      end else begin
         cfg_err <= (state == IDLE) && cfg_start && !dims_ok && !cfg_abort;
         if (start_ok) begin
            cols_last    <= cfg_cols - COL_W'(1);
            rows_last    <= cfg_rows - ROW_W'(1);
            buf_len_ctrl <= cfg_cols - COL_W'(2);
         end
         if (cfg_abort || state != RUN || last_pix) begin
            col_cnt <= '0;
            row_cnt <= '0;
         end else if (accept) begin
            if (col_end) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + ROW_W'(1);
            end else begin
               col_cnt <= col_cnt + COL_W'(1);
            end
         end
      end
   end

endmodule
